// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response interface
//
// Purpose: carries the fetch request from the fetch stage to instruction memory.
// Ports (signals):
//   imem_req   fetch side -> memory  request valid
//   imem_addr  fetch side -> memory  fetch address
//   imem_ready memory -> fetch side  imem_data valid for the address presented
//   imem_data  memory -> fetch side  fetched instruction word
// Modports: master (fetch stage), slave (memory).

interface fetch_stage_if #(
  parameter int DATA_W = 16
);
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_ready;
  logic [DATA_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_data
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, next-PC select and IF/ID register
//
// Purpose: holds the PC, issues instruction-memory fetches, applies hazard-unit
// stalls and branch/jump redirects, and drives the IF/ID pipeline register.
// Ports:
//   clk, rest                      clock (rising edge), async active-low reset
//   FrezePC, FrezeIFID             stall requests; either one stalls the stage
//   Branch_Taken, Branch_Target    taken-branch redirect (wins over Jump)
//   Jump, Jump_Target              jump redirect
//   imem (master)                  imem_req/imem_addr out, imem_ready/imem_data in
//   PC                             current fetch PC (also drives imem_addr)
//   IFID_Instr, IFID_PCPlus        instruction to ID and its PC + PC_STEP
//   IFID_Valid                     IF/ID holds a real instruction

module fetch_stage #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              FrezePC,
  input  logic              FrezeIFID,
  input  logic              Branch_Taken,
  input  logic [DATA_W-1:0] Branch_Target,
  input  logic              Jump,
  input  logic [DATA_W-1:0] Jump_Target,
  fetch_stage_if.master     imem,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] IFID_Instr,
  output logic [DATA_W-1:0] IFID_PCPlus,
  output logic              IFID_Valid
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] pc_nx, instr_nx, pcplus_nx;
  logic              valid_nx;
  // Holding buffer: an instruction that returned while the stage was stalled.
  // It is full exactly when the FSM is in HOLD.
  logic [DATA_W-1:0] buf_instr, buf_pcplus, buf_instr_nx, buf_pcplus_nx;

  logic              stall, redirect;
  logic [DATA_W-1:0] target, pc_inc;

  assign stall    = FrezePC | FrezeIFID;
  assign redirect = Branch_Taken | Jump;
  // The branch belongs to the older instruction, so it wins over a jump.
  assign target   = Branch_Taken ? Branch_Target : Jump_Target;
  assign pc_inc   = PC + STEP;

  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = PC;

  always_comb begin
    state_nx      = state;
    pc_nx         = PC;
    instr_nx      = IFID_Instr;
    pcplus_nx     = IFID_PCPlus;
    valid_nx      = IFID_Valid;
    buf_instr_nx  = buf_instr;
    buf_pcplus_nx = buf_pcplus;

    case (state)
      BOOT: state_nx = FETCH;

      FETCH: begin
        if (redirect) begin
          // Any same-cycle response belongs to the wrong path and is dropped.
          pc_nx     = target;
          instr_nx  = '0;
          pcplus_nx = '0;
          valid_nx  = 1'b0;
        end else if (stall) begin
          // IF/ID is frozen, so park a returning instruction rather than lose it.
          if (imem.imem_ready) begin
            buf_instr_nx  = imem.imem_data;
            buf_pcplus_nx = pc_inc;
            state_nx      = HOLD;
          end
        end else if (imem.imem_ready) begin
          instr_nx  = imem.imem_data;
          pcplus_nx = pc_inc;
          valid_nx  = 1'b1;
          pc_nx     = pc_inc;
        end else begin
          instr_nx  = '0;
          pcplus_nx = '0;
          valid_nx  = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_nx         = target;
          instr_nx      = '0;
          pcplus_nx     = '0;
          valid_nx      = 1'b0;
          buf_instr_nx  = '0;
          buf_pcplus_nx = '0;
          state_nx      = FETCH;
        end else if (!stall) begin
          // PC still points at the parked instruction, so advancing it here
          // resumes fetching right after it.
          instr_nx      = buf_instr;
          pcplus_nx     = buf_pcplus;
          valid_nx      = 1'b1;
          pc_nx         = pc_inc;
          buf_instr_nx  = '0;
          buf_pcplus_nx = '0;
          state_nx      = FETCH;
        end
      end

      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state       <= BOOT;
      PC          <= RESET_PC;
      IFID_Instr  <= '0;
      IFID_PCPlus <= '0;
      IFID_Valid  <= 1'b0;
      buf_instr   <= '0;
      buf_pcplus  <= '0;
    end else begin
      state       <= state_nx;
      PC          <= pc_nx;
      IFID_Instr  <= instr_nx;
      IFID_PCPlus <= pcplus_nx;
      IFID_Valid  <= valid_nx;
      buf_instr   <= buf_instr_nx;
      buf_pcplus  <= buf_pcplus_nx;
    end
  end

endmodule
